// File: rtl/out_drv_n.sv
// Registered per-channel output driver: PASS / STRETCH / BLINK / INVERT modes with output enable.
// Every output bit leaves a flop so the pads see glitch-free levels.

module out_drv_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] stretch_len,
  input  logic             blink_tick,
  input  logic             oe,
  output logic             o,
  output logic             busy
);

  typedef enum logic [1:0] {
    M_PASS    = 2'b00,
    M_STRETCH = 2'b01,
    M_BLINK   = 2'b10,
    M_INVERT  = 2'b11
  } mode_e;

  logic             i_d;
  logic [1:0]       mode_d;
  logic [CNT_W-1:0] cnt;
  logic             ph;

  logic             mode_chg;
  logic             rise;
  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] cnt_base;
  logic             ph_base;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ph_nxt;
  logic             val;

  always_comb begin
    mode_chg = (mode != mode_d);
    rise     = i & ~i_d;
    // a zero length still produces a one-cycle pulse
    len_m1   = (stretch_len == '0) ? '0 : stretch_len - CNT_W'(1);
    // a mode switch discards any pulse/blink in flight before the new mode acts
    cnt_base = mode_chg ? '0 : cnt;
    ph_base  = mode_chg ? 1'b0 : ph;
    cnt_nxt  = (cnt_base == '0) ? '0 : cnt_base - CNT_W'(1);
    ph_nxt   = ph_base;
    val      = 1'b0;
    case (mode_e'(mode))
      M_PASS:   val = i;
      M_INVERT: val = ~i;
      M_STRETCH: begin
        if (rise) begin
          cnt_nxt = len_m1;
          val     = 1'b1;
        end else begin
          val = (cnt_base != '0);
        end
      end
      M_BLINK: begin
        if (!i)              ph_nxt = 1'b0;
        else if (blink_tick) ph_nxt = ~ph_base;
        val = ph_nxt;
      end
      default: val = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_d    <= 1'b0;
      mode_d <= 2'b00;
      cnt    <= '0;
      ph     <= 1'b0;
      o      <= 1'b0;
      busy   <= 1'b0;
    end else begin
      i_d    <= i;
      mode_d <= mode;
      cnt    <= cnt_nxt;
      ph     <= ph_nxt;
      // oe only masks the pad; the counter and phase keep running underneath
      o      <= val & oe;
      busy   <= (cnt_nxt != '0);
    end
  end

endmodule

module out_drv_n #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i,
  input  logic [2*N-1:0]   mode,
  input  logic [CNT_W-1:0] stretch_len,
  input  logic             blink_tick,
  input  logic [N-1:0]     oe,
  output logic [N-1:0]     o,
  output logic [N-1:0]     busy
);

  for (genvar k = 0; k < N; k++) begin : g_lane
    out_drv_lane #(.CNT_W(CNT_W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i           (i[k]),
      .mode        (mode[2*k +: 2]),
      .stretch_len (stretch_len),
      .blink_tick  (blink_tick),
      .oe          (oe[k]),
      .o           (o[k]),
      .busy        (busy[k])
    );
  end

endmodule

// File: tb/tb_out_drv_n.sv
// Bench for out_drv_n: randomized traffic against an end-time/tick-count model, plus directed literal checks.

module tb_out_drv_n;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     i;
  logic [2*N-1:0]   mode;
  logic [CNT_W-1:0] stretch_len;
  logic             blink_tick;
  logic [N-1:0]     oe;
  logic [N-1:0]     o;
  logic [N-1:0]     busy;

  out_drv_n #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i(i), .mode(mode), .stretch_len(stretch_len),
    .blink_tick(blink_tick), .oe(oe), .o(o), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: stretch pulse = absolute last-high edge index; blink phase = parity of ticks seen while i high
  int         cyc = 0;
  int         hi_until [N];
  int         ticks [N];
  logic       pi [N];
  logic [1:0] pm [N];
  logic [N-1:0] eo, eb;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hi_until[k] = -1; ticks[k] = 0; pi[k] = 1'b0; pm[k] = 2'b00;
    end
    eo = '0; eb = '0;
  endtask

  task automatic model_step();
    int L;
    L = (stretch_len == 0) ? 1 : int'(stretch_len);
    for (int k = 0; k < N; k++) begin
      logic [1:0] m;
      logic e;
      m = mode[2*k +: 2];
      if (m != pm[k]) begin hi_until[k] = -1; ticks[k] = 0; end
      e = 1'b0;
      case (m)
        2'b00: e = i[k];
        2'b11: e = ~i[k];
        2'b01: begin
          if (i[k] && !pi[k]) hi_until[k] = cyc + L - 1;
          e = (cyc <= hi_until[k]);
        end
        default: begin
          if (!i[k]) ticks[k] = 0;
          else if (blink_tick) ticks[k]++;
          e = ticks[k][0];
        end
      endcase
      eo[k] = e & oe[k];
      eb[k] = (cyc < hi_until[k]);
      pi[k] = i[k];
      pm[k] = m;
    end
    cyc++;
  endtask

  task automatic compare();
    checks++;
    if (o !== eo) begin
      failures++;
      $display("FAIL o cyc=%0d got=%b exp=%b", cyc, o, eo);
    end
    checks++;
    if (busy !== eb) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // one clock: model follows the edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare();
  endtask

  int hi_cnt, b_cnt;
  logic [10:0] pat;

  initial begin
    rst = 1'b1; i = '0; mode = '0; stretch_len = '0; blink_tick = 1'b0; oe = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_o", int'(o), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;

    // PASS then INVERT
    oe = 4'hF; i = 4'b0101; step(); chk("pass_0101", int'(o), 4'b0101);
    i = 4'b1010; step(); chk("pass_1010", int'(o), 4'b1010);
    mode = 8'hFF; i = 4'b0101; step(); chk("inv_0101", int'(o), 4'b1010);
    i = 4'b1010; step(); chk("inv_1010", int'(o), 4'b0101);

    // STRETCH L=5 and L=0
    mode = 8'h55; i = '0; stretch_len = 8'd5; step(); step();
    for (int t = 0; t < 2; t++) begin
      hi_cnt = 0; b_cnt = 0;
      i = 4'b0001; step(); hi_cnt += o[0]; b_cnt += busy[0];
      i = '0;
      repeat (11) begin step(); hi_cnt += o[0]; b_cnt += busy[0]; end
      chk(t == 0 ? "stretch5_hi" : "stretch0_hi", hi_cnt, t == 0 ? 5 : 1);
      chk(t == 0 ? "stretch5_busy" : "stretch0_busy", b_cnt, t == 0 ? 4 : 0);
      stretch_len = 8'd0;
    end

    // retrigger three cycles after the first edge
    stretch_len = 8'd5; hi_cnt = 0;
    i = 4'b0001; step(); hi_cnt += o[0];
    i = '0; step(); hi_cnt += o[0];
    step(); hi_cnt += o[0];
    i = 4'b0001; step(); hi_cnt += o[0];
    i = '0;
    repeat (10) begin step(); hi_cnt += o[0]; end
    chk("retrigger_hi", hi_cnt, 8);

    // BLINK on channel 1, tick every 4 cycles
    mode = 8'hAA; i = '0; step(); step();
    i = 4'b0010; blink_tick = 1'b1; step(); chk("blink_t1", int'(o[1]), 1);
    blink_tick = 1'b0; repeat (3) step(); chk("blink_hold", int'(o[1]), 1);
    blink_tick = 1'b1; step(); chk("blink_t2", int'(o[1]), 0);
    blink_tick = 1'b0; repeat (3) step();
    blink_tick = 1'b1; step(); chk("blink_t3", int'(o[1]), 1);
    blink_tick = 1'b0; i = '0; step(); chk("blink_off", int'(o[1]), 0);

    // oe masking during a 10-cycle pulse on channel 2
    mode = 8'h55; stretch_len = 8'd10; step(); step();
    pat = '0;
    for (int e = 1; e <= 11; e++) begin
      i  = (e == 1) ? 4'b0100 : 4'b0000;
      oe = (e >= 4 && e <= 6) ? 4'b1011 : 4'b1111;
      step();
      pat = {pat[9:0], o[2]};
    end
    chk("oe_pattern", int'(pat), 11'b11100011110);

    // reset mid-pulse
    i = 4'b0100; step(); i = '0; repeat (3) step();
    rst = 1'b1; #1;
    chk("rst_async_o", int'(o), 0);
    chk("rst_async_busy", int'(busy), 0);
    model_reset();
    step(); step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin step(); chk("rst_no_resume", int'(o), 0); end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 15) == 0) mode[2*k +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0)  i[k] = ~i[k];
        oe[k] = ($urandom_range(0, 7) != 0);
      end
      blink_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) stretch_len = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #1;
        chk("rnd_rst_o", int'(o), 0);
        model_reset();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
